// File: rtl/store_unit.sv
// Store unit: formats sb/sh/sw stores into a word-aligned, byte-masked write and waits for dmem_resp.
// Define STORE_MISALIGN_TRAP_EN to abort misaligned sh/sw instead of silently dropping low address bits.
module store_unit #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        st_valid,
  input  logic [2:0]  st_funct3,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  output logic        st_ready,
  output logic        st_done,
  output logic        st_err,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wmask,
  output logic        dmem_write,
  input  logic        dmem_resp
);

  localparam int DATA_W = 32;
  localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT - 1);

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  logic [7:0] wait_cnt;
  logic       legal;
  logic       misaligned;

  function automatic logic [DATA_W-1:0] lane_wdata(input logic [2:0] f3,
                                                   input logic [DATA_W-1:0] d);
    case (f3)
      F3_SB:   return {4{d[7:0]}};
      F3_SH:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [3:0] lane_wmask(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      F3_SB:   return 4'b0001 << a;
      F3_SH:   return 4'b0011 << {a[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  always_comb begin
    legal      = (st_funct3 == F3_SB) || (st_funct3 == F3_SH) || (st_funct3 == F3_SW);
    misaligned = 1'b0;
`ifdef STORE_MISALIGN_TRAP_EN
    misaligned = ((st_funct3 == F3_SH) && st_addr[0]) ||
                 ((st_funct3 == F3_SW) && (st_addr[1:0] != 2'b00));
`else
    misaligned = 1'b0;
`endif
  end

  // st_err doubles as the error flag: it is only ever high in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wait_cnt   <= 8'd0;
      st_ready   <= 1'b1;
      st_done    <= 1'b0;
      st_err     <= 1'b0;
      dmem_write <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dmem_wmask <= 4'b0000;
    end else begin
      case (state)
        IDLE: begin
          st_done <= 1'b0;
          st_err  <= 1'b0;
          if (st_valid) begin
            st_ready <= 1'b0;
            if (!legal || misaligned) begin
              state   <= DONE;
              st_done <= 1'b1;
              st_err  <= 1'b1;
            end else begin
              state      <= REQ;
              wait_cnt   <= 8'd0;
              dmem_write <= 1'b1;
              dmem_addr  <= {st_addr[31:2], 2'b00};
              dmem_wdata <= lane_wdata(st_funct3, st_data);
              dmem_wmask <= lane_wmask(st_funct3, st_addr[1:0]);
            end
          end
        end
        // Response takes priority over the timeout limit in the same cycle.
        REQ: begin
          if (dmem_resp) begin
            state      <= DONE;
            dmem_write <= 1'b0;
            st_done    <= 1'b1;
            st_err     <= 1'b0;
          end else if (wait_cnt == WAIT_LIMIT) begin
            state      <= DONE;
            dmem_write <= 1'b0;
            st_done    <= 1'b1;
            st_err     <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        DONE: begin
          state    <= IDLE;
          st_done  <= 1'b0;
          st_err   <= 1'b0;
          st_ready <= 1'b1;
        end
        default: begin
          state      <= IDLE;
          st_ready   <= 1'b1;
          st_done    <= 1'b0;
          st_err     <= 1'b0;
          dmem_write <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/store_unit.md
STORE_UNIT -- requirements
Module: store_unit

Interface
REQ-001 Parameter TIMEOUT, default 64, SHALL set the maximum number of cycles spent in REQ awaiting dmem_resp (legal range 2..255).
REQ-002 Port clk, input, 1 bit: the single clock; all state SHALL update on posedge clk.
REQ-003 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 Port st_valid, input, 1 bit: core presents a store this cycle.
REQ-005 Port st_funct3, input, 3 bits: store type (000 sb, 001 sh, 010 sw).
REQ-006 Port st_addr, input, 32 bits: byte address of the store.
REQ-007 Port st_data, input, 32 bits: rs2 value, right-justified.
REQ-008 Port st_ready, output, 1 bit: unit is idle and accepts st_valid.
REQ-009 Port st_done, output, 1 bit: one-cycle pulse when a store completes or aborts.
REQ-010 Port st_err, output, 1 bit: one-cycle pulse qualifying an abort (timeout, illegal funct3, misaligned).
REQ-011 Port dmem_addr, output, 32 bits: word-aligned memory address.
REQ-012 Port dmem_wdata, output, 32 bits: lane-replicated write data.
REQ-013 Port dmem_wmask, output, 4 bits: byte-lane write enables.
REQ-014 Port dmem_write, output, 1 bit: write request, held until response.
REQ-015 Port dmem_resp, input, 1 bit: memory write acknowledge.

Function
REQ-016 FSM states IDLE, REQ, DONE; st_ready SHALL be 1 only in IDLE.
REQ-017 IDLE with st_valid and a legal, aligned store: capture address/data/mask, go to REQ next cycle.
REQ-018 IDLE with st_valid and funct3 not in {000,001,010}: go to DONE with error flag set; no memory request.
REQ-019 REQ: dmem_write = 1; dmem_addr, dmem_wdata, dmem_wmask SHALL stay constant for the whole REQ stay.
REQ-020 REQ with dmem_resp = 1: go to DONE, error flag clear.
REQ-021 REQ wait counter: cleared on REQ entry, incremented each REQ cycle without dmem_resp; at count TIMEOUT-1 without resp go to DONE with error flag set.
REQ-022 dmem_resp in the same cycle as the timeout limit: the response wins; no error.
REQ-023 DONE: st_done = 1, st_err = error flag, for exactly one cycle; then IDLE.
REQ-024 dmem_resp outside REQ SHALL be ignored.
REQ-025 Latency: st_valid accepted at edge N -> dmem_write high from N+1; resp sampled at edge M -> st_done high in cycle after M; minimum accept-to-done = 2 cycles.
REQ-026 dmem_addr = {st_addr[31:2], 2'b00}.
REQ-027 sb: wdata = data[7:0] replicated 4x; wmask = 4'b0001 << addr[1:0].
REQ-028 sh: wdata = data[15:0] replicated 2x; wmask = 4'b0011 << {addr[1],1'b0}.
REQ-029 sw: wdata = data; wmask = 4'b1111.
REQ-030 st_valid outside IDLE SHALL be ignored (core must hold it until st_ready).

Reset
REQ-031 On a posedge with rst = 1: state IDLE, counter 0, error flag 0; next cycle st_ready = 1 and st_done, st_err, dmem_write, dmem_wmask, dmem_addr, dmem_wdata = 0.
REQ-032 rst during REQ SHALL abandon the request with no st_done; dmem_write low from the cycle after the reset edge.

Configuration
REQ-033 Macro STORE_MISALIGN_TRAP_EN defined: sh with addr[0] = 1 or sw with addr[1:0] != 0 SHALL go IDLE -> DONE with error flag, no memory request.
REQ-034 Macro undefined: misaligned low address bits SHALL be ignored (sh uses addr[1] only, sw uses mask 1111); store proceeds normally.

Verification
REQ-035 sw addr 0x1000_0004 data 0xDEAD_BEEF, resp 3 cycles later -> dmem_addr 0x1000_0004, wmask 1111, wdata 0xDEADBEEF held 3 cycles, st_done=1 st_err=0.
REQ-036 sb addr 0x0000_0013 data 0x0000_00A5, resp immediate -> wmask 1000, wdata 0xA5A5A5A5, done exactly 2 cycles after accept.
REQ-037 sh addr 0x0000_0022 data 0x1234_5678, never resp, TIMEOUT=64 -> dmem_write high 64 cycles, then st_done=1 st_err=1, st_ready next cycle.
REQ-038 sw addr 0x0000_0002 -> with STORE_MISALIGN_TRAP_EN: no dmem_write, st_err=1; without: wmask 1111, addr 0x0000_0000.
REQ-039 funct3 011 -> no dmem_write, st_done=1 st_err=1 one cycle after accept.
REQ-040 rst asserted 2 cycles into REQ -> dmem_write 0, st_ready 1 the next cycle, no st_done pulse.
